// File: rtl/data_mem_lsu.sv
// RV32I load/store unit driving the data-memory port. Aligned accesses take one beat;
// misaligned halfword/word accesses are optionally split into unsigned byte beats and merged.
module data_mem_lsu #(
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        split_q;
  logic [1:0]  beat;
  logic [1:0]  last;
  logic [23:0] acc;

  logic        req_legal;
  logic        req_misal;
  logic        req_err;
  logic        req_split;
  logic [1:0]  req_last;
  logic [1:0]  beat_m1;
  logic [31:0] next_addr;
  logic [15:0] half_val;
  logic [31:0] word_val;
  logic [31:0] load_result;

  // Store data for one beat: split beats carry a single wdata byte, then lane-placed by offset.
  function automatic logic [31:0] beat_data(input logic [31:0] wdata, input logic [2:0] f3,
                                            input logic split, input logic [1:0] k,
                                            input logic [1:0] off);
    logic [31:0] raw;
    if (split) begin
      raw = {24'b0, wdata[{k, 3'b000} +: 8]};
    end else begin
      case (f3[1:0])
        2'b00:   raw = {24'b0, wdata[7:0]};
        2'b01:   raw = {16'b0, wdata[15:0]};
        default: raw = wdata;
      endcase
    end
    return raw << {off, 3'b000};
  endfunction

  function automatic logic [3:0] beat_mask(input logic [2:0] f3, input logic split,
                                           input logic write);
    logic [2:0] width;
    logic       sgn;
    case (f3[1:0])
      2'b00:   width = 3'b001;
      2'b01:   width = 3'b011;
      default: width = 3'b111;
    endcase
    sgn = !write && !f3[2] && (f3[1:0] != 2'b10);
    return split ? 4'b0001 : {sgn, width};
  endfunction

  always_comb begin
    req_legal   = 1'b0;
    req_misal   = 1'b0;
    req_err     = 1'b0;
    req_split   = 1'b0;
    req_last    = 2'd0;
    beat_m1     = beat - 2'd1;
    next_addr   = addr_q + {30'b0, beat} + 32'd1;
    half_val    = {mem_read_data[7:0], acc[7:0]};
    word_val    = {mem_read_data[7:0], acc};
    load_result = mem_read_data;

    if (req_write)
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err   = !req_legal || (req_misal && (SPLIT_MISALIGNED == 0));
    req_split = req_misal && (SPLIT_MISALIGNED != 0);
    if (req_split)
      req_last = (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;

    // Split loads were fetched as unsigned bytes, so extension happens here.
    if (split_q) begin
      if (f3_q[1:0] == 2'b01)
        load_result = f3_q[2] ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
      else
        load_result = word_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      f3_q           <= 3'b0;
      addr_q         <= 32'b0;
      wdata_q        <= 32'b0;
      write_q        <= 1'b0;
      split_q        <= 1'b0;
      beat           <= 2'd0;
      last           <= 2'd0;
      acc            <= 24'b0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'b0;
      mem_addr       <= 32'b0;
      mem_write_data <= 32'b0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= 4'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            busy    <= 1'b1;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            split_q <= req_split;
            beat    <= 2'd0;
            last    <= req_last;
            acc     <= 24'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else begin
              state          <= ISSUE;
              mem_addr       <= req_addr;
              mem_write_data <= req_write ?
                                beat_data(req_wdata, req_funct3, req_split, 2'd0, req_addr[1:0]) :
                                32'b0;
              mem_memwrite   <= req_write;
              mem_memread    <= !req_write;
              mem_sign_mask  <= beat_mask(req_funct3, req_split, req_write);
            end
          end
        end
        ISSUE: begin
          if (!write_q && (beat != 2'd0))
            acc[{beat_m1, 3'b000} +: 8] <= mem_read_data[7:0];
          if (beat == last) begin
            mem_memwrite <= 1'b0;
            mem_memread  <= 1'b0;
            if (write_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'b0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            beat           <= beat + 2'd1;
            mem_addr       <= next_addr;
            mem_write_data <= write_q ?
                              beat_data(wdata_q, f3_q, split_q, beat + 2'd1, next_addr[1:0]) :
                              32'b0;
          end
        end
        DRAIN: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_result;
        end
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: a byte-addressed memory model answers the strobes,
// and each request's beats, latency and result are compared with hand-computed values.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        busy, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_write_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'b0;

  logic        req_valid2 = 1'b0;
  logic        req_write2 = 1'b0;
  logic [2:0]  req_funct32 = 3'b0;
  logic [31:0] req_addr2 = 32'b0;
  logic [31:0] req_wdata2 = 32'b0;
  logic        busy2, resp_valid2, resp_err2;
  logic [31:0] resp_rdata2, mem_addr2, mem_write_data2;
  logic        mem_memwrite2, mem_memread2;
  logic [3:0]  mem_sign_mask2;
  logic [31:0] mem_read_data2 = 32'b0;

  int tests = 0;
  int fails = 0;

  bit [7:0] mem [bit [31:0]];

  int          waits, nbeats, resp_cyc, clash, busy_ok, resp_seen;
  logic [31:0] resp_data;
  logic        resp_e;
  logic [31:0] b_addr [0:7];
  logic [31:0] b_data [0:7];
  logic [3:0]  b_mask [0:7];
  logic        b_rd   [0:7];
  int          b_cyc  [0:7];

  always #5 clk = ~clk;

  data_mem_lsu #(.SPLIT_MISALIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  data_mem_lsu #(.SPLIT_MISALIGNED(0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_write(req_write2), .req_funct3(req_funct32),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .busy(busy2), .resp_valid(resp_valid2), .resp_err(resp_err2), .resp_rdata(resp_rdata2),
    .mem_addr(mem_addr2), .mem_write_data(mem_write_data2), .mem_memwrite(mem_memwrite2),
    .mem_memread(mem_memread2), .mem_sign_mask(mem_sign_mask2), .mem_read_data(mem_read_data2)
  );

  // Memory answers a read one cycle later with lane-shifted, extended data; junk otherwise.
  always @(posedge clk) begin
    int n;
    logic [31:0] v;
    n = (mem_sign_mask[2:0] == 3'b111) ? 4 : (mem_sign_mask[2:0] == 3'b011) ? 2 : 1;
    if (mem_memread) begin
      v = 32'b0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem[mem_addr + i];
      if (mem_sign_mask[3] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (mem_sign_mask[3] && n == 2) v = {{16{v[15]}}, v[15:0]};
      mem_read_data <= v;
    end else begin
      mem_read_data <= 32'hBAD0BAD0;
    end
    if (mem_memwrite)
      for (int i = 0; i < n; i++) mem[mem_addr + i] = mem_write_data[8*(int'(mem_addr[1:0]) + i) +: 8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    waits = 0;
    while (busy && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    nbeats = 0; resp_cyc = 0; resp_data = 32'hFFFF_FFFF; resp_e = 1'bx; busy_ok = 1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (!busy) busy_ok = 0;
      if (mem_memread && mem_memwrite) clash++;
      if (mem_memread || mem_memwrite) begin
        if (nbeats < 8) begin
          b_addr[nbeats] = mem_addr; b_data[nbeats] = mem_write_data;
          b_mask[nbeats] = mem_sign_mask; b_rd[nbeats] = mem_memread; b_cyc[nbeats] = c;
        end
        nbeats++;
      end
      if (resp_valid) begin
        resp_cyc = c; resp_data = resp_rdata; resp_e = resp_err;
        break;
      end
    end
  endtask

  initial begin
    clash = 0;
    #12;
    checkOutput("reset_ctrl", {24'b0, busy, resp_valid, resp_err, mem_memread, mem_memwrite,
                mem_sign_mask[2:0]}, 32'h0);
    checkOutput("reset_addr", mem_addr, 32'h0);
    checkOutput("reset_data", mem_write_data | resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned LW
    {mem[32'h1007], mem[32'h1006], mem[32'h1005], mem[32'h1004]} = 32'hDEADBEEF;
    applyStimulus(1'b0, 3'b010, 32'h1004, 32'h0);
    checkOutput("lw_beats", nbeats, 1);
    checkOutput("lw_beat_cyc", b_cyc[0], 1);
    checkOutput("lw_beat_rd", {31'b0, b_rd[0]}, 1);
    checkOutput("lw_addr", b_addr[0], 32'h1004);
    checkOutput("lw_mask", {28'b0, b_mask[0]}, 32'h7);
    checkOutput("lw_resp_cyc", resp_cyc, 3);
    checkOutput("lw_rdata", resp_data, 32'hDEADBEEF);
    checkOutput("lw_err", {31'b0, resp_e}, 0);
    checkOutput("lw_busy", busy_ok, 1);

    // Byte loads, signed and unsigned
    mem[32'h1003] = 8'h80;
    applyStimulus(1'b0, 3'b000, 32'h1003, 32'h0);
    checkOutput("lb_mask", {28'b0, b_mask[0]}, 32'h9);
    checkOutput("lb_rdata", resp_data, 32'hFFFFFF80);
    checkOutput("lb_resp_cyc", resp_cyc, 3);
    applyStimulus(1'b0, 3'b100, 32'h1003, 32'h0);
    checkOutput("lbu_mask", {28'b0, b_mask[0]}, 32'h1);
    checkOutput("lbu_rdata", resp_data, 32'h00000080);

    // Aligned LH
    mem[32'h1002] = 8'h01;
    applyStimulus(1'b0, 3'b001, 32'h1002, 32'h0);
    checkOutput("lh_beats", nbeats, 1);
    checkOutput("lh_mask", {28'b0, b_mask[0]}, 32'hB);
    checkOutput("lh_rdata", resp_data, 32'hFFFF8001);

    // Misaligned LW split into four byte beats
    {mem[32'h1004], mem[32'h1003], mem[32'h1002], mem[32'h1001]} = 32'h44332211;
    applyStimulus(1'b0, 3'b010, 32'h1001, 32'h0);
    checkOutput("mlw_beats", nbeats, 4);
    checkOutput("mlw_addr0", b_addr[0], 32'h1001);
    checkOutput("mlw_addr3", b_addr[3], 32'h1004);
    checkOutput("mlw_cyc3", b_cyc[3], 4);
    checkOutput("mlw_mask0", {28'b0, b_mask[0]}, 32'h1);
    checkOutput("mlw_mask3", {28'b0, b_mask[3]}, 32'h1);
    checkOutput("mlw_resp_cyc", resp_cyc, 6);
    checkOutput("mlw_rdata", resp_data, 32'h44332211);
    checkOutput("mlw_busy", busy_ok, 1);
    @(posedge clk);
    #1;
    checkOutput("mlw_busy_after", {31'b0, busy}, 0);

    // Misaligned LH / LHU: extension of the merged halfword
    mem[32'h1005] = 8'h34;
    mem[32'h1006] = 8'h92;
    applyStimulus(1'b0, 3'b001, 32'h1005, 32'h0);
    checkOutput("mlh_beats", nbeats, 2);
    checkOutput("mlh_resp_cyc", resp_cyc, 4);
    checkOutput("mlh_rdata", resp_data, 32'hFFFF9234);
    applyStimulus(1'b0, 3'b101, 32'h1005, 32'h0);
    checkOutput("mlhu_rdata", resp_data, 32'h00009234);

    // Misaligned SH across a word boundary
    applyStimulus(1'b1, 3'b001, 32'h1003, 32'h0000A55A);
    checkOutput("msh_beats", nbeats, 2);
    checkOutput("msh_addr0", b_addr[0], 32'h1003);
    checkOutput("msh_data0", b_data[0], 32'h5A000000);
    checkOutput("msh_addr1", b_addr[1], 32'h1004);
    checkOutput("msh_data1", b_data[1], 32'h000000A5);
    checkOutput("msh_rd", {31'b0, b_rd[1]}, 0);
    checkOutput("msh_resp_cyc", resp_cyc, 3);
    checkOutput("msh_rdata", resp_data, 32'h0);
    checkOutput("msh_mem", {24'b0, mem[32'h1004]}, {24'b0, 8'hA5});

    // Aligned SB at byte offset 2
    applyStimulus(1'b1, 3'b000, 32'h2006, 32'h12345677);
    checkOutput("sb_data", b_data[0], 32'h00770000);
    checkOutput("sb_mask", {28'b0, b_mask[0]}, 32'h1);
    checkOutput("sb_mem", {24'b0, mem[32'h2006]}, 32'h77);

    // Illegal funct3 on a load and on a store
    applyStimulus(1'b0, 3'b011, 32'h1000, 32'h0);
    checkOutput("ill_ld_beats", nbeats, 0);
    checkOutput("ill_ld_resp_cyc", resp_cyc, 1);
    checkOutput("ill_ld_err", {31'b0, resp_e}, 1);
    checkOutput("ill_ld_rdata", resp_data, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h1000, 32'hFFFFFFFF);
    checkOutput("ill_st_beats", nbeats, 0);
    checkOutput("ill_st_err", {31'b0, resp_e}, 1);

    // Misaligned LH rejected when splitting is disabled
    @(negedge clk);
    req_valid2 = 1'b1; req_write2 = 1'b0; req_funct32 = 3'b001; req_addr2 = 32'h1001;
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    checkOutput("nosplit_resp", {30'b0, resp_valid2, resp_err2}, 32'h3);
    checkOutput("nosplit_rdata", resp_rdata2, 32'h0);
    checkOutput("nosplit_strobe", {30'b0, mem_memread2, mem_memwrite2}, 0);
    @(posedge clk);
    #1;
    checkOutput("nosplit_pulse", {30'b0, resp_valid2, busy2}, 0);

    // Back-to-back SW then LW
    applyStimulus(1'b1, 3'b010, 32'h2000, 32'hCAFEF00D);
    checkOutput("sw_resp_cyc", resp_cyc, 2);
    checkOutput("sw_data", b_data[0], 32'hCAFEF00D);
    checkOutput("sw_mask", {28'b0, b_mask[0]}, 32'h7);
    applyStimulus(1'b0, 3'b010, 32'h2000, 32'h0);
    checkOutput("b2b_waits", waits, 1);
    checkOutput("b2b_rdata", resp_data, 32'hCAFEF00D);
    checkOutput("b2b_resp_cyc", resp_cyc, 3);

    // Reset asserted during beat 2 of a split LW
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1001;
    waits = 0;
    while (busy && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_beat2_addr", mem_addr, 32'h1003);
    checkOutput("rst_beat2_rd", {31'b0, mem_memread}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_drop", {29'b0, mem_memread, mem_memwrite, busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid || busy) resp_seen++;
    end
    checkOutput("rst_no_resp", resp_seen, 0);

    applyStimulus(1'b0, 3'b010, 32'h2000, 32'h0);
    checkOutput("recover_rdata", resp_data, 32'hCAFEF00D);
    checkOutput("strobe_clash", clash, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
